pwm_generator: RTL
==================

Name: pwm_generator

Overview:
- Downstream consumer of the SPI register bank's five 8-bit control registers.
- Drives 16 output pins `out[15:0]`; each pin is off, statically on, or PWM-modulated.
- Contains a clock prescaler, an 8-bit PWM period counter, a duty comparator and a registered per-pin output mux.
- Sits between the register bank and the top-level `uo_out`/`uio_out` pin assignment.

Parameters:
- CLK_DIV, 3000, system clocks per PWM counter step (10 MHz / 3000 / 256 ≈ 13 Hz default period; legal range 1..65535).
- PRE_W, 16, prescaler counter width; must satisfy 2^PRE_W ≥ CLK_DIV.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- en_reg_out_7_0  input  8  output enable, pins 7..0.
- en_reg_out_15_8  input  8  output enable, pins 15..8.
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0.
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8.
- pwm_duty_cycle  input  8  duty value; 0x00 = 0 %, 0xFF = 100 %.
- out  output  16  pin drive, registered.
- period_start  output  1  one-clk pulse at the first clk of each PWM period.

Behaviour:
- Reset (rst high at a clk edge):
  - pre_cnt=0, pwm_cnt=0, out=16'h0000, period_start=0, duty shadow=0.
  - Reset mid-period aborts the period; counting restarts from 0 on the first clk with rst low.
- Prescaler:
  - pre_cnt counts 0..CLK_DIV-1 and wraps.
  - tick=1 for exactly one clk when pre_cnt==CLK_DIV-1.
  - CLK_DIV=1 ⇒ tick every clk.
- Period counter:
  - pwm_cnt (8 bit) increments on tick and wraps 255→0 with no extra cycle.
  - Period = 256*CLK_DIV clks.
- period_start:
  - Registered; asserted for one clk on the clk after tick coincides with pwm_cnt==255.
  - Also asserted on the first clk after reset release.
- Compare (duty = shadow or live, see Optional Feature):
  - pwm_high = (duty==8'hFF) | (pwm_cnt < duty), unsigned 8-bit compare.
  - duty 0x00 ⇒ never high.
  - duty 0xFF ⇒ constant high, no one-step glitch.
  - duty N (1..254) ⇒ high for exactly N*CLK_DIV clks per period, starting at the period start.
- Per-pin mux, for i in 0..15, using en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i]=0 ⇒ 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 ⇒ 1.
  - en_out[i]=1, en_pwm[i]=1 ⇒ pwm_high.
  - out is registered: one clk latency from any input or counter change to out.
- Enable register changes take effect on the next clk, mid-period allowed.
- All PWM pins are phase-aligned; they share one counter.

Optional Feature:
- Macro: PWM_SHADOW_EN.
- Defined:
  - duty is a shadow register, loaded from pwm_duty_cycle only when tick & pwm_cnt==255, and on reset release (loaded on the first clk with rst low).
  - A duty write mid-period takes effect at the next period start.
  - No runt pulses.
- Undefined:
  - duty = pwm_duty_cycle directly.
  - A mid-period change affects the current period immediately.
  - Enable registers are never shadowed in either build.

Decomposition:
- Shared package `pwm_pkg`:
  - localparams PWM_CNT_W=8, DUTY_FULL=8'hFF, NUM_PINS=16.
  - Default CLK_DIV constant.
- One natural sub-module, `pwm_prescaler`:
  - Parameters CLK_DIV, PRE_W.
  - Ports clk, rst, tick.
  - Instantiated once.
- Comparator, shadow register and output mux stay in pwm_generator.

Test Plan (CLK_DIV=4, period 1024 clks):
- Reset, all enables 0, duty=0x80 → out=0x0000 for 2048 clks; period_start pulses every 1024 clks.
- en_out=0xFFFF, en_pwm=0x0000 → out=0xFFFF one clk after the register update; constant.
- en_out=0x0001, en_pwm=0x0001, duty=0x80 → out[0] high 512 clks, low 512 clks, rising edge one clk after period_start; out[15:1]=0.
- en_out=en_pwm=0xFFFF; duty 0x00 → out constantly 0; duty 0xFF → out constantly 0xFFFF; duty 0x01 → 4-clk high pulse per period.
- PWM_SHADOW_EN defined, duty 0x40→0xC0 at pwm_cnt=100 → current period high 256 clks, next period high 768 clks. Undefined → change visible within 2 clks.
- Assert rst at pwm_cnt=200 with out[0]=1 → out=0 on the next clk; after release, pwm_cnt restarts at 0 and period_start pulses on the first clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and the duty comparator for the PWM generator.
package pwm_pkg;

  localparam int PWM_CNT_W       = 8;
  localparam int NUM_PINS        = 16;
  localparam int CLK_DIV_DEFAULT = 3000;
  localparam int PRE_W_DEFAULT   = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  // Full-scale duty is forced high so the last counter step never drops out.
  function automatic logic duty_high(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_generator_if.sv
// Control-register inputs and pin outputs between the register bank and the PWM generator.
interface pwm_generator_if;

  logic [7:0]                    en_reg_out_7_0;
  logic [7:0]                    en_reg_out_15_8;
  logic [7:0]                    en_reg_pwm_7_0;
  logic [7:0]                    en_reg_pwm_15_8;
  logic [pwm_pkg::PWM_CNT_W-1:0] pwm_duty_cycle;
  logic [pwm_pkg::NUM_PINS-1:0]  out;
  logic                          period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Divides the system clock: tick is high for one clk every CLK_DIV clks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int PRE_W   = PRE_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == PRE_LAST);

  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/pwm_generator.sv
// 16-pin PWM generator: shared period counter, duty compare, registered per-pin mux.
// Optional macro PWM_SHADOW_EN latches the duty value only at period boundaries.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int PRE_W   = PRE_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  pwm_generator_if.slave  bus
);

  logic                  tick;
  logic                  wrap;
  logic                  first_q;
  logic [PWM_CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [PWM_CNT_W-1:0]  duty;
  logic                  pwm_high;
  logic [NUM_PINS-1:0]   en_out, en_pwm;
  logic [NUM_PINS-1:0]   out_q, out_d;
  logic                  period_start_q, period_start_d;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV),
    .PRE_W   (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap   = tick && (pwm_cnt_q == '1);
  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
  logic [PWM_CNT_W-1:0] duty_q, duty_d;

  always_comb begin
    duty_d = duty_q;
    if (first_q || wrap) duty_d = bus.pwm_duty_cycle;
  end

  // The shadow is still empty in the first clk after reset, so compare the live value then.
  assign duty = first_q ? bus.pwm_duty_cycle : duty_q;

  always_ff @(posedge clk) begin
    if (rst) duty_q <= '0;
    else     duty_q <= duty_d;
  end
`else
  assign duty = bus.pwm_duty_cycle;
`endif

  always_comb begin
    pwm_cnt_d      = tick ? pwm_cnt_q + PWM_CNT_W'(1) : pwm_cnt_q;
    period_start_d = first_q || wrap;
    pwm_high       = duty_high(pwm_cnt_q, duty);
    out_d          = (en_out & ~en_pwm) | (en_out & en_pwm & {NUM_PINS{pwm_high}});
  end

  // Output register stage: one clk from any input or counter change to the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q        <= 1'b1;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      first_q        <= 1'b0;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule
